// File: rtl/hex_dump_sequencer_if.sv
// Bundled signals of the hex dump sequencer: control, register read port,
// shared hex converter and byte-wide transmit stream.
interface hex_dump_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       reg_data;
    logic [7:0]        conv_bin;
    logic [15:0]       conv_ascii;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    // master: the sequencer; slave: register file, converter and transmitter side
    modport master (
        input  start, reg_data, conv_ascii, tx_ready,
        output busy, done, reg_addr, conv_bin, tx_data, tx_valid
    );

    modport slave (
        output start, reg_data, conv_ascii, tx_ready,
        input  busy, done, reg_addr, conv_bin, tx_data, tx_valid
    );
endinterface

// File: rtl/hex_dump_sequencer.sv
// Streams the register file as "xNN=HHHHHHHH\r\n" lines, one per register,
// time-sharing a single external byte-to-ASCII-hex converter.
module hex_dump_sequencer #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    hex_dump_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [3:0]        LAST_K   = 4'd13;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [3:0]        k_q, k_d;
    logic [31:0]       word_q, word_d;

    logic              sending;
    logic [7:0]        idx_byte;
    logic [7:0]        sel_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            k_q     <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        k_d     = k_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                // Snapshot the word so later register writes cannot tear the line
                word_d  = bus.reg_data;
                k_d     = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (bus.tx_ready) begin
                    if (k_q == LAST_K) begin
                        if (idx_q < LAST_IDX) begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from registered state only, so reset clears them at once
    // and they hold still while the transmitter stalls.
    always_comb begin
        sending  = (state_q == S_SEND);
        idx_byte = 8'(idx_q);
        sel_byte = 8'h00;
        case (k_q)
            4'd1, 4'd2:   sel_byte = idx_byte;
            4'd4, 4'd5:   sel_byte = word_q[31:24];
            4'd6, 4'd7:   sel_byte = word_q[23:16];
            4'd8, 4'd9:   sel_byte = word_q[15:8];
            4'd10, 4'd11: sel_byte = word_q[7:0];
            default:      sel_byte = 8'h00;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q != S_IDLE);
        bus.done     = (state_q == S_DONE);
        bus.tx_valid = sending;
        bus.reg_addr = idx_q;
        bus.conv_bin = sending ? sel_byte : 8'h00;
        bus.tx_data  = 8'h00;
        if (sending) begin
            case (k_q)
                4'd0:                             bus.tx_data = 8'h78;
                4'd3:                             bus.tx_data = 8'h3D;
                4'd12:                            bus.tx_data = 8'h0D;
                4'd13:                            bus.tx_data = 8'h0A;
                4'd1, 4'd4, 4'd6, 4'd8, 4'd10:    bus.tx_data = bus.conv_ascii[15:8];
                4'd2, 4'd5, 4'd7, 4'd9, 4'd11:    bus.tx_data = bus.conv_ascii[7:0];
                default:                          bus.tx_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_dump_sequencer.sv
// Directed bench for hex_dump_sequencer: models the register file and the
// shared hex converter, captures the TX stream and compares against expectations.
module tb_hex_dump_sequencer;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int LINE     = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hex_dump_sequencer_if #(.ADDR_W(ADDR_W)) hif();

    hex_dump_sequencer #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    logic [31:0] regs [NUM_REGS];
    logic [7:0]  rx[$];
    logic [7:0]  exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
    endfunction

    assign hif.reg_data   = regs[hif.reg_addr];
    assign hif.conv_ascii = {hexc(hif.conv_bin[7:4]), hexc(hif.conv_bin[3:0])};

    function automatic void build_exp();
        logic [7:0]  r;
        logic [31:0] w;
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) begin
            r = 8'(i);
            w = regs[i];
            exp_q.push_back(8'h78);
            exp_q.push_back(hexc(r[7:4]));
            exp_q.push_back(hexc(r[3:0]));
            exp_q.push_back(8'h3D);
            for (int j = 7; j >= 0; j--) exp_q.push_back(hexc(w[j*4 +: 4]));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endfunction

    function automatic int first_diff();
        int m;
        m = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
        for (int i = 0; i < m; i++) if (rx[i] !== exp_q[i]) return i;
        if (rx.size() != exp_q.size()) return m;
        return -1;
    endfunction

    function automatic string line_str(input int n);
        string s;
        s = "............";
        if (rx.size() < (n + 1) * LINE) return "short";
        for (int i = 0; i < 12; i++) s[i] = rx[n*LINE + i];
        return s;
    endfunction

    function automatic bit line_term(input int n);
        if (rx.size() < (n + 1) * LINE) return 1'b0;
        return (rx[n*LINE + 12] === 8'h0D) && (rx[n*LINE + 13] === 8'h0A);
    endfunction

    // Runs one dump; ready is high with probability duty%. Captures each transfer.
    task automatic run_dump(input int duty, input int mid_start_idx, input bit chg5,
                            output int viol, output int busy_cyc, output int done_cnt,
                            output int done_at, output bit timeout);
        bit         prev_stall;
        bit         ms_done;
        logic [7:0] pd, pb;
        int         post;
        viol = 0; busy_cyc = 0; done_cnt = 0; done_at = -1; timeout = 1'b1;
        prev_stall = 1'b0; ms_done = 1'b0; post = 0; pd = '0; pb = '0;
        rx.delete();
        @(negedge clk); #1;
        hif.start    = 1'b1;
        hif.tx_ready = ($urandom_range(0, 99) < duty);
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk); #1;
            hif.start = 1'b0;
            if (prev_stall && (!hif.tx_valid || hif.tx_data !== pd || hif.conv_bin !== pb))
                viol++;
            if (hif.busy) busy_cyc++;
            if (hif.done) begin
                if (done_cnt == 0) done_at = cyc;
                done_cnt++;
            end
            if (done_cnt > 0) post++;
            if (post >= 4) begin
                timeout = 1'b0;
                break;
            end
            if (mid_start_idx >= 0 && !ms_done && hif.busy && int'(hif.reg_addr) == mid_start_idx) begin
                hif.start = 1'b1;
                ms_done   = 1'b1;
            end
            if (chg5 && rx.size() == 5*LINE + 6) regs[5] = 32'h2222_2222;
            hif.tx_ready = ($urandom_range(0, 99) < duty);
            if (hif.tx_valid && hif.tx_ready) rx.push_back(hif.tx_data);
            prev_stall = hif.tx_valid && !hif.tx_ready;
            pd = hif.tx_data;
            pb = hif.conv_bin;
        end
        hif.start = 1'b0;
    endtask

    task automatic test_reset();
        hif.start = 1'b0; hif.tx_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_assert++; if (hif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", hif.busy); end
        n_assert++; if (hif.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", hif.tx_valid); end
        rst = 1'b0;
        @(negedge clk); #1;
        n_assert++; if (hif.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", hif.done); end
        n_assert++; if (hif.reg_addr !== '0) begin n_fail++; $display("FAIL reset_reg_addr: got %0d want 0", hif.reg_addr); end
        n_assert++; if (hif.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", hif.tx_data); end
        n_assert++; if (hif.conv_bin !== 8'h00) begin n_fail++; $display("FAIL reset_conv_bin: got %h want 00", hif.conv_bin); end
    endtask

    task automatic test_first_line();
        int cyc;
        rx.delete();
        hif.tx_ready = 1'b1;
        @(negedge clk); #1;
        hif.start = 1'b1;
        for (cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk); #1;
            hif.start = 1'b0;
            if (cyc < 2) begin
                n_assert++;
                if (hif.tx_valid !== 1'b0) begin n_fail++; $display("FAIL first_latency_c%0d: tx_valid got %b want 0", cyc, hif.tx_valid); end
            end
            if (cyc == 2) begin
                n_assert++;
                if (hif.tx_valid !== 1'b1 || hif.tx_data !== 8'h78)
                    begin n_fail++; $display("FAIL first_char: got v=%b d=%h want v=1 d=78", hif.tx_valid, hif.tx_data); end
            end
            if (hif.tx_valid && hif.tx_ready) rx.push_back(hif.tx_data);
            if (!hif.busy) break;
        end
        n_assert++; if (cyc >= 2000) begin n_fail++; $display("FAIL first_timeout: got %0d cycles want <2000", cyc); end
        n_assert++;
        if (line_str(0) != "x00=00000000" || !line_term(0))
            begin n_fail++; $display("FAIL line0: got %s term=%b want x00=00000000 term=1", line_str(0), line_term(0)); end
    endtask

    task automatic test_full_dump();
        int viol, bc, dc, da; bit to;
        build_exp();
        run_dump(100, -1, 1'b0, viol, bc, dc, da, to);
        n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL full_timeout: got %b want 0", to); end
        n_assert++; if (bc !== 513) begin n_fail++; $display("FAIL full_busy_cycles: got %0d want 513", bc); end
        n_assert++; if (dc !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", dc); end
        n_assert++; if (da !== 512) begin n_fail++; $display("FAIL full_done_at: got %0d want 512", da); end
        n_assert++;
        if (line_str(1) != "x01=DEADBEEF" || !line_term(1))
            begin n_fail++; $display("FAIL line1: got %s term=%b want x01=DEADBEEF term=1", line_str(1), line_term(1)); end
        n_assert++;
        if (line_str(31) != "x1F=0123ABCD" || !line_term(31))
            begin n_fail++; $display("FAIL line31: got %s term=%b want x1F=0123ABCD term=1", line_str(31), line_term(31)); end
        n_assert++;
        if (first_diff() !== -1) begin n_fail++; $display("FAIL full_stream: first diff at %0d, got %0d chars want %0d", first_diff(), rx.size(), exp_q.size()); end
    endtask

    task automatic test_random_ready();
        int viol, bc, dc, da; bit to;
        build_exp();
        run_dump(30, -1, 1'b0, viol, bc, dc, da, to);
        n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand_timeout: got %b want 0", to); end
        n_assert++; if (viol !== 0) begin n_fail++; $display("FAIL rand_stall_stable: got %0d violations want 0", viol); end
        n_assert++; if (rx.size() !== 448) begin n_fail++; $display("FAIL rand_len: got %0d want 448", rx.size()); end
        n_assert++;
        if (first_diff() !== -1) begin n_fail++; $display("FAIL rand_stream: first diff at %0d", first_diff()); end
        n_assert++; if (dc !== 1) begin n_fail++; $display("FAIL rand_done_count: got %0d want 1", dc); end
    endtask

    task automatic test_reg_change();
        int viol, bc, dc, da; bit to;
        regs[5] = 32'h1111_1111;
        build_exp();
        run_dump(100, -1, 1'b1, viol, bc, dc, da, to);
        n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL chg_timeout: got %b want 0", to); end
        n_assert++;
        if (line_str(5) != "x05=11111111") begin n_fail++; $display("FAIL chg_line5: got %s want x05=11111111", line_str(5)); end
        n_assert++;
        if (first_diff() !== -1) begin n_fail++; $display("FAIL chg_stream: first diff at %0d", first_diff()); end
        regs[5] = 32'h1111_1111;
    endtask

    task automatic test_mid_start();
        int viol, bc, dc, da; bit to;
        build_exp();
        run_dump(100, 10, 1'b0, viol, bc, dc, da, to);
        n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL mid_timeout: got %b want 0", to); end
        n_assert++; if (dc !== 1) begin n_fail++; $display("FAIL mid_done_count: got %0d want 1", dc); end
        n_assert++; if (bc !== 513) begin n_fail++; $display("FAIL mid_busy_cycles: got %0d want 513", bc); end
        n_assert++;
        if (first_diff() !== -1) begin n_fail++; $display("FAIL mid_stream: first diff at %0d", first_diff()); end
    endtask

    task automatic test_reset_abort();
        int viol, bc, dc, da; bit to; bit hit;
        hit = 1'b0;
        rx.delete();
        hif.tx_ready = 1'b1;
        @(negedge clk); #1;
        hif.start = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk); #1;
            hif.start = 1'b0;
            if (hif.tx_valid && rx.size() == 7*LINE + 6) begin
                hit = 1'b1;
                break;
            end
            if (hif.tx_valid && hif.tx_ready) rx.push_back(hif.tx_data);
        end
        n_assert++; if (hit !== 1'b1) begin n_fail++; $display("FAIL abort_reach_k6: got %b want 1", hit); end
        n_assert++; if (hif.reg_addr !== 5'd7) begin n_fail++; $display("FAIL abort_pre_addr: got %0d want 7", hif.reg_addr); end
        rst = 1'b1;
        #1;
        n_assert++;
        if (hif.tx_valid !== 1'b0 || hif.busy !== 1'b0 || hif.reg_addr !== '0)
            begin n_fail++; $display("FAIL abort_async: got v=%b busy=%b addr=%0d want 0 0 0", hif.tx_valid, hif.busy, hif.reg_addr); end
        @(negedge clk); #1;
        rst = 1'b0;
        build_exp();
        run_dump(100, -1, 1'b0, viol, bc, dc, da, to);
        n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL abort_timeout: got %b want 0", to); end
        n_assert++;
        if (rx.size() < 4 || rx[0] !== 8'h78 || rx[1] !== 8'h30 || rx[2] !== 8'h30 || rx[3] !== 8'h3D)
            begin n_fail++; $display("FAIL abort_restart: got %s want x00=", line_str(0)); end
        n_assert++;
        if (first_diff() !== -1) begin n_fail++; $display("FAIL abort_stream: first diff at %0d", first_diff()); end
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] = {4{8'(i)}};
        regs[1]  = 32'hDEAD_BEEF;
        regs[5]  = 32'h1111_1111;
        regs[31] = 32'h0123_ABCD;
        hif.start    = 1'b0;
        hif.tx_ready = 1'b0;
        test_reset();
        test_first_line();
        test_full_dump();
        test_random_ready();
        test_reg_change();
        test_mid_start();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
